// File: rtl/fifo_pkt_writer.sv
// rtl/fifo_pkt_writer.sv - store-and-forward packet producer feeding the dual-clock FIFO write port
module fifo_pkt_writer #(
  parameter int DSIZE = 8,
  parameter int PSIZE = 4
) (
  input  logic             wclk,
  input  logic             rrst_n,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             pkt_sent,
  output logic             pkt_drop,
  output logic             busy
);

  localparam logic [PSIZE:0] MAX_PKT = {1'b1, {PSIZE{1'b0}}};

  typedef enum logic [1:0] {FILL, DROP, HDR, PAY} state_t;

  state_t           state;
  logic [PSIZE:0]   cnt;
  logic [PSIZE:0]   len;
  logic [PSIZE-1:0] idx;
  logic [DSIZE-1:0] pkt_buf [MAX_PKT];

  logic accept;
  logic room;
  logic last_pay;

  assign s_ready  = (state == FILL) || (state == DROP);
  assign busy     = (state != FILL);
  assign winc     = ((state == HDR) || (state == PAY)) && !wfull;
  assign accept   = s_valid && s_ready;
  assign room     = (cnt < MAX_PKT);
  assign last_pay = ({1'b0, idx} == (len - 1'b1));

  always_comb begin
    wdata = '0;
    case (state)
      HDR:     wdata = DSIZE'(len);
      PAY:     wdata = pkt_buf[idx];
      default: wdata = '0;
    endcase
  end

  // Payload storage carries no reset; only words below len are ever read.
  always_ff @(posedge wclk) begin
    if (state == FILL && accept && room)
      pkt_buf[cnt[PSIZE-1:0]] <= s_data;
  end

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= FILL;
      cnt      <= '0;
      len      <= '0;
      idx      <= '0;
      pkt_sent <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      pkt_sent <= 1'b0;
      pkt_drop <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (room) begin
              if (s_last) begin
                len   <= cnt + 1'b1;
                cnt   <= '0;
                state <= HDR;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              // Word MAX_PKT+1: the packet is oversize, discard the rest.
              cnt <= '0;
              if (s_last)
                pkt_drop <= 1'b1;
              else
                state <= DROP;
            end
          end
        end
        DROP: begin
          if (accept && s_last) begin
            pkt_drop <= 1'b1;
            state    <= FILL;
          end
        end
        HDR: begin
          if (winc) begin
            idx   <= '0;
            state <= PAY;
          end
        end
        PAY: begin
          if (winc) begin
            if (last_pay) begin
              pkt_sent <= 1'b1;
              idx      <= '0;
              state    <= FILL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/fifo_pkt_writer.md
Name: fifo_pkt_writer

Overview:
Store-and-forward packet producer for the write side of the dual-clock FIFO. It accepts a valid/ready word stream delimited by a last flag and buffers one whole packet internally. It then writes the packet into the FIFO as a length header word followed by the payload words, honouring FIFO backpressure through wfull. Oversize packets are discarded and flagged. The block lives entirely in the write clock domain.

Parameters:
DSIZE, 8, data word width; must equal the FIFO DSIZE and satisfy DSIZE >= PSIZE+1.
PSIZE, 4, log2 of maximum payload length; MAX_PKT = 1<<PSIZE words (default 16).

Ports:
wclk  input  1  write-domain clock; all logic on posedge.
rrst_n  input  1  reset, asynchronous, active-low.
s_valid  input  1  upstream word valid.
s_data  input  DSIZE  upstream word.
s_last  input  1  marks final word of packet; qualified by s_valid.
s_ready  output  1  block accepts the word this cycle.
wfull  input  1  FIFO full flag, write domain.
winc  output  1  FIFO write strobe.
wdata  output  DSIZE  FIFO write data.
pkt_sent  output  1  one-cycle pulse when the last payload word is written.
pkt_drop  output  1  one-cycle pulse when an oversize packet has been fully discarded.
busy  output  1  high in HDR, PAY or DROP.

Behaviour:
- Clock wclk; reset rrst_n, asynchronous, active-low.
- Reset values: state=FILL, cnt=0, len=0, idx=0, pkt_sent=0, pkt_drop=0.
- Reset outputs: winc=0, wdata=0, s_ready=1, busy=0.
- Buffer: MAX_PKT x DSIZE register array. Buffer contents are not reset.
- Accept: a word is accepted when s_valid && s_ready. No word is accepted while s_ready=0.
- Write: a word is written when winc=1. winc is combinational: (state==HDR || state==PAY) && !wfull. winc is never high while wfull=1.
- wdata: len in HDR, buf[idx] in PAY, 0 otherwise.
- FILL state, s_ready=1:
  - On accept with cnt<MAX_PKT: buf[cnt] <= s_data, cnt <= cnt+1.
  - If the accepted word has s_last=1: len <= cnt+1 (width PSIZE+1, zero-extended to DSIZE), cnt <= 0, go to HDR.
  - On accept with cnt==MAX_PKT (word MAX_PKT+1): the word is discarded and cnt <= 0.
    - If s_last=1: pulse pkt_drop and stay in FILL.
    - Otherwise go to DROP.
- DROP state, s_ready=1: discard all accepted words. On accept with s_last=1, pulse pkt_drop and go to FILL.
- HDR state, s_ready=0: on write, idx <= 0 and go to PAY. Stall indefinitely while wfull=1.
- PAY state, s_ready=0: on write, idx <= idx+1.
  - When the word written has idx==len-1: pulse pkt_sent, idx <= 0, go to FILL.
  - Stall while wfull=1, holding idx. No word is skipped or duplicated.
- Latency: header winc can assert in the cycle after the s_last word is accepted. With no backpressure, a packet of N words emits N+1 writes on consecutive cycles.
- Packet length 1 is legal: header 1, then one payload word.
- Packet length MAX_PKT is legal: header = MAX_PKT.
- Zero-length packets cannot occur, since s_last always marks a real word.
- pkt_sent and pkt_drop are registered one-cycle pulses and never overlap.
- wfull rising mid-PAY stalls the transfer. wfull falling resumes it on that cycle at the held idx.
- Reset mid-operation:
  - The state machine returns to FILL asynchronously, so winc drops immediately.
  - The partially buffered or partially written packet is lost. The downstream FIFO is reset with it by system convention.
  - After rrst_n releases, the first accepted word starts a new packet at cnt=0.
- s_data and s_last are don't-care when s_valid=0.

Test Plan:
- Words 0xA1, 0xB2, 0xC3 (last on 0xC3), wfull=0 -> winc high 4 consecutive cycles carrying 0x03, 0xA1, 0xB2, 0xC3. pkt_sent pulses with the 0xC3 write. s_ready=0 from the cycle after 0xC3 is accepted until back in FILL.
- Same 3-word packet with wfull=1 for 3 cycles after the 0xA1 write -> winc=0 during those cycles, then 0xB2, 0xC3. Exactly 4 writes total, no repeats.
- Single word 0x5E with last=1 -> writes 0x01, 0x5E. pkt_sent pulses once.
- 16-word packet 0x00..0x0F -> header 0x10 followed by 0x00..0x0F in order.
- 17-word packet (last on word 17) -> zero writes, one pkt_drop pulse. A following 2-word packet 0x11, 0x22 -> writes 0x02, 0x11, 0x22.
- rrst_n asserted while in PAY after 2 payload writes -> winc=0 in the same cycle, busy=0, s_ready=1. After release, a new 1-word packet 0x77 -> writes 0x01, 0x77.
